// File: rtl/gcn_pkg.sv
// Shared types, default sizes and the COO index range check used by the GCN
// aggregation edge scheduler.
package gcn_pkg;

    localparam int COO_EDGE_ROW = 2;
    localparam int COO_WIDTH    = 3;
    localparam int COO_EDGES    = 6;
    localparam int FEATURE_ROWS = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        LATCH = 3'd3,
        FWD   = 3'd4,
        REV   = 3'd5,
        DONE  = 3'd6
    } sched_state_t;

    // COO node indices are 1-based, so 0 and anything above the node count are invalid
    function automatic logic coo_idx_valid(input int unsigned idx, input int unsigned rows);
        return (idx >= 32'd1) && (idx <= rows);
    endfunction

endpackage

// File: rtl/coo_edge_scheduler.sv
// Walks the COO edge list and issues the two symmetric accumulate commands
// (a-1 -> b-1, b-1 -> a-1) per valid edge over a valid/ready handshake.
module coo_edge_scheduler #(
    parameter int COO_EDGE_ROW    = gcn_pkg::COO_EDGE_ROW,
    parameter int COO_WIDTH       = gcn_pkg::COO_WIDTH,
    parameter int COO_EDGES       = gcn_pkg::COO_EDGES,
    parameter int FEATURE_ROWS    = gcn_pkg::FEATURE_ROWS,
    parameter int FEATURE_WIDTH   = $clog2(FEATURE_ROWS),
    parameter int COO_EDGES_WIDTH = $clog2(COO_EDGES),
    parameter int EDGE_CNT_WIDTH  = $clog2(COO_EDGES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       done_trans,
    output logic                       coo_rd_en,
    output logic [COO_EDGES_WIDTH-1:0] coo_address,
    input  logic [COO_WIDTH-1:0]       coo_in [0:COO_EDGE_ROW-1],
    output logic                       out_clear,
    output logic                       acc_valid,
    input  logic                       acc_ready,
    output logic [FEATURE_WIDTH-1:0]   acc_src_row,
    output logic [FEATURE_WIDTH-1:0]   acc_dst_row,
    output logic [EDGE_CNT_WIDTH-1:0]  edge_count,
    output logic                       busy,
    output logic                       err_index,
    output logic                       done
);

    import gcn_pkg::*;

    sched_state_t               state_q, state_d;
    logic [EDGE_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic [COO_WIDTH-1:0]       a_q, a_d;
    logic [COO_WIDTH-1:0]       b_q, b_d;
    logic                       retire_s;
    logic                       edge_ok_s;
    logic [COO_WIDTH-1:0]       a_m1_s, b_m1_s;

    logic                       coo_rd_en_q, coo_rd_en_d;
    logic [COO_EDGES_WIDTH-1:0] coo_address_q, coo_address_d;
    logic                       out_clear_q, out_clear_d;
    logic                       acc_valid_q, acc_valid_d;
    logic [FEATURE_WIDTH-1:0]   acc_src_row_q, acc_src_row_d;
    logic [FEATURE_WIDTH-1:0]   acc_dst_row_q, acc_dst_row_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    // Next-state, edge bookkeeping and next values of every registered output
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        a_d           = a_q;
        b_d           = b_q;
        retire_s      = 1'b0;
        edge_ok_s     = coo_idx_valid(32'(coo_in[0]), FEATURE_ROWS) &&
                        coo_idx_valid(32'(coo_in[1]), FEATURE_ROWS);

        case (state_q)
            IDLE, DONE: begin
                // Counter and sticky error are cleared on entry so they read 0 during CLEAR
                if (start && done_trans) begin
                    state_d = CLEAR;
                    cnt_d   = {EDGE_CNT_WIDTH{1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            CLEAR: state_d = FETCH;
            FETCH: state_d = LATCH;
            LATCH: begin
                a_d = coo_in[0];
                b_d = coo_in[1];
                if (edge_ok_s) begin
                    state_d = FWD;
                end else begin
                    err_d    = 1'b1;
                    retire_s = 1'b1;
                end
            end
            FWD: begin
                if (acc_ready) begin
                    if (a_q == b_q) begin
                        retire_s = 1'b1;
                    end else begin
                        state_d = REV;
                    end
                end else begin
                    state_d = FWD;
                end
            end
            REV: begin
                if (acc_ready) begin
                    retire_s = 1'b1;
                end else begin
                    state_d = REV;
                end
            end
            default: state_d = IDLE;
        endcase

        if (retire_s) begin
            cnt_d   = cnt_q + {{(EDGE_CNT_WIDTH-1){1'b0}}, 1'b1};
            state_d = (cnt_d == EDGE_CNT_WIDTH'(COO_EDGES)) ? DONE : FETCH;
        end else begin
            cnt_d = cnt_d;
        end

        // Decrement only matters once the indices have passed the range check
        a_m1_s = a_d - {{(COO_WIDTH-1){1'b0}}, 1'b1};
        b_m1_s = b_d - {{(COO_WIDTH-1){1'b0}}, 1'b1};

        coo_rd_en_d   = (state_d == FETCH);
        coo_address_d = COO_EDGES_WIDTH'(cnt_d);
        out_clear_d   = (state_d == CLEAR);
        acc_valid_d   = (state_d == FWD) || (state_d == REV);
        busy_d        = (state_d != IDLE) && (state_d != DONE);
        done_d        = (state_d == DONE);

        case (state_d)
            FWD: begin
                acc_src_row_d = FEATURE_WIDTH'(a_m1_s);
                acc_dst_row_d = FEATURE_WIDTH'(b_m1_s);
            end
            REV: begin
                acc_src_row_d = FEATURE_WIDTH'(b_m1_s);
                acc_dst_row_d = FEATURE_WIDTH'(a_m1_s);
            end
            default: begin
                acc_src_row_d = {FEATURE_WIDTH{1'b0}};
                acc_dst_row_d = {FEATURE_WIDTH{1'b0}};
            end
        endcase
    end

    // State, edge registers and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= {EDGE_CNT_WIDTH{1'b0}};
            err_q         <= 1'b0;
            a_q           <= {COO_WIDTH{1'b0}};
            b_q           <= {COO_WIDTH{1'b0}};
            coo_rd_en_q   <= 1'b0;
            coo_address_q <= {COO_EDGES_WIDTH{1'b0}};
            out_clear_q   <= 1'b0;
            acc_valid_q   <= 1'b0;
            acc_src_row_q <= {FEATURE_WIDTH{1'b0}};
            acc_dst_row_q <= {FEATURE_WIDTH{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            a_q           <= a_d;
            b_q           <= b_d;
            coo_rd_en_q   <= coo_rd_en_d;
            coo_address_q <= coo_address_d;
            out_clear_q   <= out_clear_d;
            acc_valid_q   <= acc_valid_d;
            acc_src_row_q <= acc_src_row_d;
            acc_dst_row_q <= acc_dst_row_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign coo_rd_en   = coo_rd_en_q;
    assign coo_address = coo_address_q;
    assign out_clear   = out_clear_q;
    assign acc_valid   = acc_valid_q;
    assign acc_src_row = acc_src_row_q;
    assign acc_dst_row = acc_dst_row_q;
    assign edge_count  = cnt_q;
    assign busy        = busy_q;
    assign err_index   = err_q;
    assign done        = done_q;

endmodule

// File: tb/tb_coo_edge_scheduler.sv
// Directed, table-driven bench for coo_edge_scheduler: full passes with hand-computed
// command lists and completion cycles, plus idle-start and mid-pass reset sequences.
module tb_coo_edge_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done_trans;
    logic       coo_rd_en;
    logic [2:0] coo_address;
    logic [2:0] coo_in [0:1];
    logic       out_clear;
    logic       acc_valid;
    logic       acc_ready;
    logic [2:0] acc_src_row;
    logic [2:0] acc_dst_row;
    logic [2:0] edge_count;
    logic       busy;
    logic       err_index;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [2:0] mem_a [6];
    logic [2:0] mem_b [6];

    typedef struct packed {
        logic [5:0][2:0]  ea;
        logic [5:0][2:0]  eb;
        logic [7:0]       stall;
        logic [7:0]       mid_start;
        logic [7:0]       ncmd;
        logic [11:0][5:0] cmds;
        logic [7:0]       done_rel;
        logic             err;
    } vec_t;

    vec_t vecs [5];

    coo_edge_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done_trans  (done_trans),
        .coo_rd_en   (coo_rd_en),
        .coo_address (coo_address),
        .coo_in      (coo_in),
        .out_clear   (out_clear),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_src_row (acc_src_row),
        .acc_dst_row (acc_dst_row),
        .edge_count  (edge_count),
        .busy        (busy),
        .err_index   (err_index),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // COO memory: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (coo_rd_en) begin
            coo_in[0] <= mem_a[coo_address];
            coo_in[1] <= mem_b[coo_address];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {coo_rd_en, coo_address, out_clear, acc_valid, acc_src_row,
                acc_dst_row, edge_count, busy, err_index, done};
    endfunction

    task automatic load_mem(input vec_t t);
        for (int i = 0; i < 6; i++) begin
            mem_a[i] = t.ea[i];
            mem_b[i] = t.eb[i];
        end
    endtask

    task automatic run_vec(input int v);
        vec_t       t;
        logic [5:0] got [16];
        int         n, s, done_rel, clr_cnt, clr_rel, busy_bad, stalls;
        logic       finished, release_rdy, prev_stall;
        logic [2:0] prev_src, prev_dst;
        t = vecs[v];
        load_mem(t);
        for (int i = 0; i < 16; i++) got[i] = 6'd0;
        n = 0; done_rel = -1; clr_cnt = 0; clr_rel = -1; busy_bad = 0; stalls = 0;
        finished = 1'b0; release_rdy = 1'b0; prev_stall = 1'b0;
        prev_src = 3'd0; prev_dst = 3'd0;

        tick();
        start      = 1'b1;
        done_trans = 1'b1;
        acc_ready  = (t.stall == 8'd0);
        s          = cyc;
        for (int k = 1; k <= 200 && !finished; k++) begin
            tick();
            start      = (k == int'(t.mid_start));
            done_trans = start;
            if (release_rdy) acc_ready = 1'b1;
            @(negedge clk);
            if (cyc - s != k) chk($sformatf("v%0d cycle align", v), 64'(cyc - s), 64'(k));
            if (k == 1) chk($sformatf("v%0d done drops", v), 64'(done), 64'd0);
            if (prev_stall) begin
                chk($sformatf("v%0d stall valid", v), 64'(acc_valid), 64'd1);
                chk($sformatf("v%0d stall src", v), 64'(acc_src_row), 64'(prev_src));
                chk($sformatf("v%0d stall dst", v), 64'(acc_dst_row), 64'(prev_dst));
            end
            prev_stall = acc_valid && !acc_ready;
            prev_src   = acc_src_row;
            prev_dst   = acc_dst_row;
            if (acc_valid && !acc_ready) begin
                stalls++;
                if (stalls >= int'(t.stall)) release_rdy = 1'b1;
            end
            if (acc_valid && acc_ready && n < 16) begin
                got[n] = {acc_src_row, acc_dst_row};
                n++;
            end
            if (out_clear) begin
                clr_cnt++;
                clr_rel = k;
            end
            if (!done && !busy) busy_bad++;
            if (done) begin
                done_rel = k;
                finished = 1'b1;
            end
        end
        chk($sformatf("v%0d done cycle", v), 64'(done_rel), 64'(t.done_rel));
        chk($sformatf("v%0d command count", v), 64'(n), 64'(t.ncmd));
        for (int i = 0; i < 12; i++) begin
            if (i < int'(t.ncmd)) chk($sformatf("v%0d cmd%0d src/dst", v, i), 64'(got[i]), 64'(t.cmds[i]));
        end
        chk($sformatf("v%0d err_index", v), 64'(err_index), 64'(t.err));
        chk($sformatf("v%0d edge_count", v), 64'(edge_count), 64'd6);
        chk($sformatf("v%0d busy at done", v), 64'(busy), 64'd0);
        chk($sformatf("v%0d out_clear pulses", v), 64'(clr_cnt), 64'd1);
        chk($sformatf("v%0d out_clear cycle", v), 64'(clr_rel), 64'd1);
        chk($sformatf("v%0d busy during pass", v), 64'(busy_bad), 64'd0);
        tick();
        @(negedge clk);
        chk($sformatf("v%0d done held", v), 64'({done, edge_count, err_index}), 64'({1'b1, 3'd6, t.err}));
    endtask

    initial begin
        int s, clr_seen;
        clk        = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        done_trans = 1'b0;
        acc_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_a[i] = 3'd0;
            mem_b[i] = 3'd0;
        end

        // Edge lists and expected commands are written last-element-first; cmd octal = {src,dst}
        vecs[0] = '0;
        vecs[0].ea       = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1};
        vecs[0].eb       = {3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
        vecs[0].ncmd     = 8'd12;
        vecs[0].cmds     = {6'o54, 6'o45, 6'o53, 6'o35, 6'o42, 6'o24,
                            6'o31, 6'o13, 6'o20, 6'o02, 6'o10, 6'o01};
        vecs[0].done_rel = 8'd26;
        vecs[0].err      = 1'b0;

        vecs[1] = '0;
        vecs[1].ea       = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd3};
        vecs[1].eb       = {3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd3};
        vecs[1].ncmd     = 8'd11;
        vecs[1].cmds     = {6'o00, 6'o54, 6'o45, 6'o53, 6'o35, 6'o42,
                            6'o24, 6'o31, 6'o13, 6'o20, 6'o02, 6'o22};
        vecs[1].done_rel = 8'd25;
        vecs[1].err      = 1'b0;

        vecs[2] = '0;
        vecs[2].ea       = {3'd5, 3'd7, 3'd3, 3'd0, 3'd1, 3'd1};
        vecs[2].eb       = {3'd6, 3'd1, 3'd5, 3'd4, 3'd3, 3'd2};
        vecs[2].ncmd     = 8'd8;
        vecs[2].cmds     = {6'o00, 6'o00, 6'o00, 6'o00, 6'o54, 6'o45,
                            6'o42, 6'o24, 6'o20, 6'o02, 6'o10, 6'o01};
        vecs[2].done_rel = 8'd22;
        vecs[2].err      = 1'b1;

        vecs[3]          = vecs[0];
        vecs[3].stall    = 8'd3;
        vecs[3].done_rel = 8'd29;

        vecs[4]           = vecs[0];
        vecs[4].mid_start = 8'd10;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("reset outputs", 64'(all_outs()), 64'd0);
        reset = 1'b0;

        // Start without done_trans is dropped
        tick();
        start      = 1'b1;
        done_trans = 1'b0;
        clr_seen   = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            if (out_clear || busy) clr_seen++;
        end
        chk("start w/o done_trans ignored", 64'(clr_seen), 64'd0);
        chk("idle outputs", 64'(all_outs()), 64'd0);

        // Passes back to back; each after the first starts from DONE
        for (int v = 0; v < 5; v++) run_vec(v);

        // Reset during REV of edge 3, edge (3,5): REV command is src 4, dst 2
        load_mem(vecs[0]);
        tick();
        start      = 1'b1;
        done_trans = 1'b1;
        s          = cyc;
        tick();
        start      = 1'b0;
        done_trans = 1'b0;
        while (cyc - s < 17) tick();
        @(negedge clk);
        chk("edge3 rev before reset", 64'({acc_valid, acc_src_row, acc_dst_row}), 64'({1'b1, 3'd4, 3'd2}));
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("outputs after mid-pass reset", 64'(all_outs()), 64'd0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("stays idle after reset", 64'({busy, done, out_clear}), 64'd0);
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coo_edge_scheduler.md
Name: coo_edge_scheduler

Overview:
Sequences the GCN aggregation phase, once the FM×W transformation has finished.
- Walks the COO edge memory one edge at a time and range-checks each edge.
- For every valid edge (a,b), issues two accumulate commands to the aggregation datapath: row a-1 into row b-1, and row b-1 into row a-1.
- Edge indices in COO memory are 1-based; commands use 0-based rows.
- Replaces free-running edge stepping with an explicit FSM, a valid/ready command handshake and sticky error reporting.

Parameters:
COO_EDGE_ROW, 2, entries per COO edge (source, destination)
COO_WIDTH, 3, bit width of one COO node index
COO_EDGES, 6, number of edges stored in COO memory
FEATURE_ROWS, 6, number of graph nodes (rows of FM×W and of the output)
FEATURE_WIDTH, $clog2(FEATURE_ROWS), row-select width
COO_EDGES_WIDTH, $clog2(COO_EDGES), COO memory address width
EDGE_CNT_WIDTH, $clog2(COO_EDGES+1), width of the processed-edge counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin an aggregation pass
done_trans  in  1  FM×W result memory complete and stable
coo_rd_en  out  1  COO memory read strobe
coo_address  out  COO_EDGES_WIDTH  COO memory edge address
coo_in  in  COO_WIDTH × COO_EDGE_ROW (unpacked [0:COO_EDGE_ROW-1])  edge read data, valid the cycle after coo_rd_en
out_clear  out  1  one-cycle pulse: clear output accumulator memory
acc_valid  out  1  accumulate command valid
acc_ready  in  1  datapath accepts the command
acc_src_row  out  FEATURE_WIDTH  FM×W row to read
acc_dst_row  out  FEATURE_WIDTH  output row to accumulate into
edge_count  out  EDGE_CNT_WIDTH  edges retired this pass
busy  out  1  pass in progress
err_index  out  1  sticky: at least one edge skipped as out of range
done  out  1  pass complete; held high until the next start

Behaviour:
- Reset (synchronous, active-high): state IDLE; every output 0; index registers 0. Reset wins over all other inputs and aborts a pass mid-operation, including a pending acc_valid, with no completion.
- IDLE / DONE: if start && done_trans → CLEAR.
  - start without done_trans is ignored, not queued.
  - start while busy is ignored.
- CLEAR (1 cycle): out_clear=1; edge counter, address, err_index and done cleared → FETCH.
- FETCH (1 cycle): coo_rd_en=1, coo_address=edge counter → LATCH.
- LATCH (1 cycle): capture a=coo_in[0], b=coo_in[1].
  - Valid edge: 1 ≤ a ≤ FEATURE_ROWS and 1 ≤ b ≤ FEATURE_ROWS.
  - Invalid edge: set err_index, retire the edge with no commands → NEXT logic.
  - Valid edge → FWD.
- FWD: acc_valid=1, src=a-1, dst=b-1.
  - Held stable until acc_valid && acc_ready. src/dst must not change while valid is high without ready.
  - On the handshake: if a==b (self loop), retire the edge, since one command only; else → REV.
- REV: acc_valid=1, src=b-1, dst=a-1. On the handshake, retire the edge.
- Retire / NEXT (same cycle as the final handshake or the invalid decision):
  - edge_count+1.
  - If the new count == COO_EDGES → DONE; else → FETCH, with address = new count.
- DONE: done=1, busy=0; edge_count holds the final value.
- busy=1 in every state except IDLE and DONE.
- Arithmetic rules:
  - The index-1 subtraction is done at COO_WIDTH width, then truncated to FEATURE_WIDTH; it is performed only after the range check.
  - Address width never wraps, because the counter stops at COO_EDGES.
- Latency with acc_ready tied 1:
  - Normal edge: 4 cycles.
  - Self loop: 3 cycles.
  - Invalid edge: 2 cycles.
  - Pass: start at cycle 0 → out_clear at cycle 1 → done high from cycle 2 + Σ(edge latencies).
- done_trans dropping mid-pass is ignored; it is sampled only at start.
- COO_EDGES==0 is not a legal configuration.

Decomposition:
- Package gcn_pkg:
  - state enum sched_state_t {IDLE, CLEAR, FETCH, LATCH, FWD, REV, DONE}.
  - Shared default constants COO_EDGES, FEATURE_ROWS, COO_WIDTH.
  - A function coo_idx_valid(idx) for the range check.
- Single module, no sub-module. The FSM, counter and index registers are tightly coupled, so splitting them gains nothing.

Test Plan:
1. Edges {(1,2),(1,3),(2,4),(3,5),(4,6),(5,6)}, acc_ready=1, start@0 → out_clear@1; 12 commands in order (0→1, 1→0, 0→2, 2→0, …); done rises @26; edge_count=6; err_index=0.
2. Edge 0 = (3,3), others as in test 1 → exactly one command src=2, dst=2 for that edge; 11 commands total; done @25.
3. Edge 2 = (0,4) and edge 4 = (7,1) → no commands for those edges; err_index=1 and sticky; edge_count=6; 8 commands; done @22.
4. acc_ready low for 3 cycles during FWD of edge 0 → acc_valid, src=0 and dst=1 stable for all stall cycles; completion shifts by exactly 3 cycles.
5. start with done_trans=0 → stays IDLE, busy=0. Then start during a pass → ignored. Then start in DONE with done_trans=1 → new pass; done drops; out_clear pulses.
6. Reset asserted during REV of edge 3 → next cycle all outputs 0 and state IDLE; a new start runs a full pass from edge 0 with correct results.
